// File: rtl/gf2_sys_pkg.sv
// gf2_sys_pkg -- shared types for the GF(2) row systemizer.
//   state_e        : systemizer FSM states
//   row_op_e       : update operation applied to the row file in a cycle
//   gf2_sys_clog2  : address-width helper (never returns less than 1)
package gf2_sys_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PIVOT,
      ST_SWAP,
      ST_ELIM,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_WRITE,
      OP_SWAP,
      OP_XOR
   } row_op_e;

   function automatic int gf2_sys_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/gf2_row_file.sv
// gf2_row_file -- ROWS x COLS bit matrix storage for the systemizer.
// Ports:
//   clk              : clock
//   op               : update this cycle (none / write / swap / xor)
//   addr_a, addr_b   : target row (write, xor) or the two rows to swap
//   wdata            : row value for write, xor mask for xor
//   c_idx, r_idx     : pivot-column row and scan row selects
//   rd_idx           : readback row select
//   c_row, r_row, rd_row : combinational reads of the selected rows
// The array is deliberately not reset.
module gf2_row_file
   import gf2_sys_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 16,
   localparam int AW = gf2_sys_clog2(ROWS)
) (
   input  logic            clk,
   input  row_op_e         op,
   input  logic [AW-1:0]   addr_a,
   input  logic [AW-1:0]   addr_b,
   input  logic [COLS-1:0] wdata,
   input  logic [AW-1:0]   c_idx,
   input  logic [AW-1:0]   r_idx,
   input  logic [AW-1:0]   rd_idx,
   output logic [COLS-1:0] c_row,
   output logic [COLS-1:0] r_row,
   output logic [COLS-1:0] rd_row
);

   logic [COLS-1:0] row_q [ROWS];

   always_ff @(posedge clk) begin
      case (op)
         OP_WRITE: row_q[addr_a] <= wdata;
         OP_SWAP: begin
            row_q[addr_a] <= row_q[addr_b];
            row_q[addr_b] <= row_q[addr_a];
         end
         OP_XOR:   row_q[addr_a] <= row_q[addr_a] ^ wdata;
         default: ;
      endcase
   end

   assign c_row  = row_q[c_idx];
   assign r_row  = row_q[r_idx];
   assign rd_row = row_q[rd_idx];

endmodule

// File: rtl/gf2_row_systemizer.sv
// gf2_row_systemizer -- Gauss-Jordan reduction over GF(2) of the left
// ROWS x ROWS block of a ROWS x COLS matrix, one row operation per cycle.
// Column c of the matrix is row bit COLS-1-c (the MSB is column 0).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : begin systemization (accepted in IDLE/DONE)
//   busy                : FSM in PIVOT/SWAP/ELIM
//   done                : one-cycle pulse on entry to DONE
//   success / fail      : left block became identity / left block singular
//   wr_en/addr/data     : row load (IDLE/DONE only, not with start)
//   rd_en/addr, rd_data : registered row readback, 1-cycle latency
//   cycle_cnt           : busy-cycle count, only with GF2_SYS_CYCLE_CNT_EN
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, rows writable
// ST_PIVOT | scanning rows r >= c for a 1 in column c
// ST_SWAP  | exchanging row c with pivot row p
// ST_ELIM  | clearing column c in every other row, one row per cycle
// ST_DONE  | result held, rows writable, start restarts
module gf2_row_systemizer
   import gf2_sys_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 16,
   localparam int AW = gf2_sys_clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            success,
   output logic            fail,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [COLS-1:0] wr_data,
   input  logic            rd_en,
   input  logic [AW-1:0]   rd_addr,
   output logic [COLS-1:0] rd_data
`ifdef GF2_SYS_CYCLE_CNT_EN
   ,
   output logic [15:0]     cycle_cnt
`endif
);

   localparam int CW = gf2_sys_clog2(COLS);
   localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   c_q, c_d, r_q, r_d, p_q, p_d;
   logic            done_q, done_d, success_q, success_d, fail_q, fail_d;
   logic [COLS-1:0] rd_data_q, rd_data_d;

   row_op_e         op;
   logic [AW-1:0]   addr_a, addr_b;
   logic [COLS-1:0] wdata, c_row, r_row, rd_row;
   logic [CW-1:0]   col_bit;
   logic            r_hit, start_ok;

   gf2_row_file #(.ROWS(ROWS), .COLS(COLS)) u_rows (
      .clk    (clk),
      .op     (op),
      .addr_a (addr_a),
      .addr_b (addr_b),
      .wdata  (wdata),
      .c_idx  (c_q),
      .r_idx  (r_q),
      .rd_idx (rd_addr),
      .c_row  (c_row),
      .r_row  (r_row),
      .rd_row (rd_row)
   );

   assign col_bit  = CW'(COLS - 1) - CW'(c_q);
   assign r_hit    = r_row[col_bit];
   assign busy     = (state_q == ST_PIVOT) || (state_q == ST_SWAP) || (state_q == ST_ELIM);
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      r_d       = r_q;
      p_d       = p_q;
      done_d    = 1'b0;
      success_d = success_q;
      fail_d    = fail_q;
      op        = OP_NOP;
      addr_a    = wr_addr;
      addr_b    = p_q;
      wdata     = wr_data;
      rd_data_d = rd_en ? rd_row : rd_data_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               success_d = 1'b0;
               fail_d    = 1'b0;
               c_d       = '0;
               r_d       = '0;
               state_d   = ST_PIVOT;
            end else if (wr_en) begin
               op = OP_WRITE;
            end
         end
         ST_PIVOT: begin
            if (r_hit) begin
               p_d     = r_q;
               state_d = ST_SWAP;
            end else if (r_q == LAST) begin
               fail_d  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               r_d = r_q + AW'(1);
            end
         end
         ST_SWAP: begin
            // p == c writes each row back onto itself
            op      = OP_SWAP;
            addr_a  = c_q;
            addr_b  = p_q;
            r_d     = '0;
            state_d = ST_ELIM;
         end
         ST_ELIM: begin
            if ((r_q != c_q) && r_hit) begin
               op     = OP_XOR;
               addr_a = r_q;
               wdata  = c_row;
            end
            if (r_q == LAST) begin
               if (c_q == LAST) begin
                  success_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  c_d     = c_q + AW'(1);
                  r_d     = c_q + AW'(1);
                  state_d = ST_PIVOT;
               end
            end else begin
               r_d = r_q + AW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         c_q       <= '0;
         r_q       <= '0;
         p_q       <= '0;
         done_q    <= 1'b0;
         success_q <= 1'b0;
         fail_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         r_q       <= r_d;
         p_q       <= p_d;
         done_q    <= done_d;
         success_q <= success_d;
         fail_q    <= fail_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign done    = done_q;
   assign success = success_q;
   assign fail    = fail_q;
   assign rd_data = rd_data_q;

`ifdef GF2_SYS_CYCLE_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_ok)
         cnt_d = '0;
      else if (busy && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cycle_cnt = cnt_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_gf2_row_systemizer.sv
module tb_gf2_row_systemizer;

   localparam int ROWS = 4;
   localparam int COLS = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] wr_data = '0;
   logic       busy, done, success, fail;
   logic [7:0] rd_data;
`ifdef GF2_SYS_CYCLE_CNT_EN
   logic [15:0] cycle_cnt;
`endif

   gf2_row_systemizer #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .success (success),
      .fail    (fail),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
`ifdef GF2_SYS_CYCLE_CNT_EN
      ,
      .cycle_cnt (cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit succ;
      bit fl;
      int done_cyc;
      int cnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rd_exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   bit         rd_pend = 0;
   bit         done_prev = 0;

   logic [7:0] ld[ROWS];
   logic [7:0] mdl[ROWS];
   logic [7:0] rb[ROWS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Reference: Gauss-Jordan over GF(2) with the per-column cycle costs
   // (scan rows c..p, one swap cycle, ROWS elimination cycles).
   task automatic model_run(output bit ok, output int busy_cyc);
      logic [7:0] t;
      int p;
      ok = 1;
      busy_cyc = 0;
      for (int c = 0; c < ROWS; c++) begin
         p = -1;
         for (int r = c; r < ROWS; r++)
            if (p < 0 && mdl[r][COLS-1-c]) p = r;
         if (p < 0) begin
            busy_cyc += ROWS - c;
            ok = 0;
            break;
         end
         busy_cyc += (p - c + 1) + 1 + ROWS;
         t = mdl[c]; mdl[c] = mdl[p]; mdl[p] = t;
         for (int r = 0; r < ROWS; r++)
            if (r != c && mdl[r][COLS-1-c]) mdl[r] = mdl[r] ^ mdl[c];
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rd_pend <= rd_en;
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      logic [7:0] re;
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               check("success", 32'(success), 32'(e.succ));
               check("fail", 32'(fail), 32'(e.fl));
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
`ifdef GF2_SYS_CYCLE_CNT_EN
               check("cycle_cnt", 32'(cycle_cnt), 32'(e.cnt));
`endif
            end
         end
         if (done && done_prev) begin
            errors++;
            $display("FAIL done_pulse_width actual=2+ required=1 at cycle %0d", cyc);
         end
         if (success && fail) begin
            errors++;
            $display("FAIL success_and_fail actual=11 required=not_both at cycle %0d", cyc);
         end
         done_prev = done;
         if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_read actual=%0h required=none", rd_data);
            end else begin
               re = rd_exp_q.pop_front();
               check("rd_data", 32'(rd_data), 32'(re));
            end
         end
      end else begin
         done_prev = 0;
      end
   end

   task automatic load();
      for (int i = 0; i < ROWS; i++) begin
         @(negedge clk);
         wr_en = 1; wr_addr = 2'(i); wr_data = ld[i];
      end
      @(negedge clk);
      wr_en = 0;
   endtask

   task automatic readback();
      for (int i = 0; i < ROWS; i++) begin
         @(negedge clk);
         rd_en = 1; rd_addr = 2'(i);
         rd_exp_q.push_back(rb[i]);
      end
      @(negedge clk);
      rd_en = 0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=no_done required=done within 400 cycles");
      end
   endtask

   // exp_b >= 0 fixes the busy-cycle count independently of the model
   task automatic run(input int exp_b, input bit wr_in_start, input bit wr_busy, input bit chk_clear);
      bit ok;
      int b;
      exp_t e;
      for (int i = 0; i < ROWS; i++) mdl[i] = ld[i];
      model_run(ok, b);
      if (exp_b >= 0) b = exp_b;
      @(negedge clk);
      start = 1;
      if (wr_in_start) begin wr_en = 1; wr_addr = 0; wr_data = ~ld[0]; end
      @(posedge clk);
      #1;
      e.succ = ok; e.fl = !ok; e.done_cyc = cyc + b; e.cnt = b;
      exp_q.push_back(e);
      if (chk_clear) begin
         check("fail_cleared_on_start", 32'(fail), 0);
         check("busy_after_start", 32'(busy), 1);
      end
      @(negedge clk);
      start = 0; wr_en = 0;
      if (wr_busy) begin
         wr_en = 1; wr_addr = 1; wr_data = ~ld[1];
         @(negedge clk);
         wr_en = 0;
      end
      wait_done();
      for (int i = 0; i < ROWS; i++) rb[i] = mdl[i];
      readback();
      check("success_held", 32'(success), 32'(ok));
      check("fail_held", 32'(fail), 32'(!ok));
   endtask

   initial begin
      int perm[ROWS];
      int j, t, mode;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_success", 32'(success), 0);
      check("rst_fail", 32'(fail), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      rst_n = 1;

      // identity: rows unchanged, 24 busy cycles
      ld[0] = 8'h80; ld[1] = 8'h40; ld[2] = 8'h20; ld[3] = 8'h10;
      load();
      run(24, 0, 0, 0);

      // pairwise swapped identity
      ld[0] = 8'h40; ld[1] = 8'h80; ld[2] = 8'h10; ld[3] = 8'h20;
      load();
      for (int i = 0; i < ROWS; i++) mdl[i] = ld[i];
      run(-1, 0, 0, 0);

      // all zero: fail in column 0, then restart clears fail
      ld[0] = 8'h00; ld[1] = 8'h00; ld[2] = 8'h00; ld[3] = 8'h00;
      load();
      run(4, 0, 0, 0);
      run(4, 0, 0, 1);

      // fail at column 1: 6 cycles for column 0, 3 scanning column 1
      ld[0] = 8'h8F; ld[1] = 8'h8F; ld[2] = 8'h20; ld[3] = 8'h10;
      load();
      run(9, 0, 0, 0);

      // writes in the start-accept cycle and while busy are ignored
      ld[0] = 8'h80; ld[1] = 8'h40; ld[2] = 8'h20; ld[3] = 8'h10;
      load();
      run(24, 1, 1, 0);

      for (int it = 0; it < 14; it++) begin
         mode = $urandom_range(0, 2);
         for (int i = 0; i < ROWS; i++) perm[i] = i;
         for (int i = ROWS - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
         for (int i = 0; i < ROWS; i++) begin
            case (mode)
               0: ld[i] = 8'($urandom);
               1: ld[i] = (8'h80 >> perm[i]) | 8'($urandom_range(0, 15));
               default: ld[i] = 8'($urandom & $urandom & $urandom);
            endcase
         end
         if (mode == 1) begin
            j = $urandom_range(1, ROWS - 1);
            ld[0] = ld[0] ^ ld[j];
         end
         load();
         run(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // async reset in ELIM; a write issued while busy must not land
      ld[0] = 8'h80; ld[1] = 8'h40; ld[2] = 8'h20; ld[3] = 8'h10;
      load();
      @(negedge clk);
      rd_en = 1; rd_addr = 0;
      rd_exp_q.push_back(8'h80);
      @(negedge clk);
      rd_en = 0;
      @(negedge clk);
      check("rd_hold", 32'(rd_data), 32'h80);
      start = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      start = 0; wr_en = 1; wr_addr = 3; wr_data = 8'h00;
      @(negedge clk);
      wr_en = 0;
      @(negedge clk);
      check("busy_in_elim", 32'(busy), 1);
      #2 rst_n = 0;
      #1;
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      check("async_rst_success", 32'(success), 0);
      check("async_rst_fail", 32'(fail), 0);
      check("async_rst_rd_data", 32'(rd_data), 0);
`ifdef GF2_SYS_CYCLE_CNT_EN
      check("async_rst_cycle_cnt", 32'(cycle_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      check("idle_after_rst", 32'(busy), 0);
      check("no_done_after_rst", 32'(done), 0);
      for (int i = 0; i < ROWS; i++) rb[i] = ld[i];
      readback();

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_done actual=%0d required=0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks);
      $fatal(1, "watchdog");
   end

endmodule
